// File: rtl/load_use_stall_unit_pkg.sv
// Shared MIPS definitions: opcodes, hazard-unit state encoding and operand-use decode.
package mips_defs;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    typedef enum logic [1:0] {
        StRun   = 2'd0,
        StStall = 2'd1,
        StHold  = 2'd2
    } state_e;

    // SW is left out on purpose: its store data is forwarded in MEM, only its rs matters.
    function automatic logic uses_rt(input logic [5:0] op);
        return (op == OP_RTYPE) || (op == OP_BEQ) || (op == OP_BNE);
    endfunction

endpackage

// File: rtl/load_use_stall_unit_if.sv
// Pipeline-register view and control outputs of the load-use stall unit.
interface load_use_stall_unit_if #(
    parameter int unsigned CNT_W = 16
);
    logic [5:0]       ifid_op;
    logic [4:0]       ifid_rs;
    logic [4:0]       ifid_rt;
    logic [5:0]       idex_op;
    logic [4:0]       idex_rt;
    logic [5:0]       exmem_op;
    logic [4:0]       exmem_rd;
    logic             mem_ready;
    logic             pc_write;
    logic             ifid_write;
    logic             idex_flush;
    logic             pipe_hold;
    logic [CNT_W-1:0] stall_cycles;
    logic [CNT_W-1:0] hold_cycles;
    logic             mem_timeout;

    // Pipeline side: supplies stage contents, consumes the stall/hold controls.
    modport master (
        output ifid_op, ifid_rs, ifid_rt, idex_op, idex_rt, exmem_op, exmem_rd, mem_ready,
        input  pc_write, ifid_write, idex_flush, pipe_hold, stall_cycles, hold_cycles,
               mem_timeout
    );

    // Hazard unit side.
    modport slave (
        input  ifid_op, ifid_rs, ifid_rt, idex_op, idex_rt, exmem_op, exmem_rd, mem_ready,
        output pc_write, ifid_write, idex_flush, pipe_hold, stall_cycles, hold_cycles,
               mem_timeout
    );

endinterface

// File: rtl/load_use_stall_unit_sat_counter.sv
// Saturating up-counter with synchronous clear; clear wins over increment.
module sat_counter #(
    parameter int unsigned   W   = 16,
    parameter logic [W-1:0]  MAX = {W{1'b1}}
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic         inc_i,
    input  logic         clr_i,
    output logic [W-1:0] cnt_o
);

    logic [W-1:0] cnt_q, cnt_d;

    // Next count: clear, hold at MAX, or increment.
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (inc_i && (cnt_q != MAX)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // Count register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/load_use_stall_unit.sv
// Load-use / memory-busy hazard controller beside the ID stage. Outputs are Mealy on
// the live pipeline-register contents; a memory hold overrides a load-use bubble.
module load_use_stall_unit
    import mips_defs::*;
#(
    parameter int unsigned CNT_W   = 16,
    parameter int unsigned TIMEOUT = 64
) (
    input  logic                  clock,
    input  logic                  reset_n,
    load_use_stall_unit_if.slave  bus
);

    localparam int unsigned     TmrW   = $clog2(TIMEOUT + 1);
    localparam logic [TmrW-1:0] TmrMax = TmrW'(TIMEOUT);

    state_e           state_q, state_d;
    logic             live_q;
    logic             tmo_q;
    logic             lu_ex, lu_br, is_br, mem_busy;
    logic             out_en, hold_act, stall_act;
    logic [TmrW-1:0]  timer;
    logic [CNT_W-1:0] stall_cnt, hold_cnt;

    // Hazard detection on the current stage contents; register 0 never hazards.
    always_comb begin
        is_br    = (bus.ifid_op == OP_BEQ) || (bus.ifid_op == OP_BNE);
        lu_ex    = (bus.idex_op == OP_LW) && (bus.idex_rt != 5'd0) &&
                   ((bus.idex_rt == bus.ifid_rs) ||
                    (uses_rt(bus.ifid_op) && (bus.idex_rt == bus.ifid_rt)));
        lu_br    = is_br && (bus.exmem_op == OP_LW) && (bus.exmem_rd != 5'd0) &&
                   ((bus.exmem_rd == bus.ifid_rs) || (bus.exmem_rd == bus.ifid_rt));
        mem_busy = ((bus.exmem_op == OP_LW) || (bus.exmem_op == OP_SW)) && !bus.mem_ready;
    end

    // RUN outputs are forced while in reset and until the first clock edge after it.
    assign out_en    = reset_n && live_q;
    assign hold_act  = out_en && mem_busy;
    assign stall_act = out_en && !mem_busy && (lu_ex || lu_br);

    // Mealy control outputs with hold taking priority over a bubble.
    always_comb begin
        bus.pc_write   = !(hold_act || stall_act);
        bus.ifid_write = !(hold_act || stall_act);
        bus.idex_flush = stall_act;
        bus.pipe_hold  = hold_act;
    end

    // Next state: HOLD releases to RUN; RUN and STALL re-evaluate the priority rule.
    always_comb begin
        state_d = StRun;
        unique case (state_q)
            StHold: state_d = hold_act ? StHold : StRun;
            default: begin
                if (hold_act) begin
                    state_d = StHold;
                end else if (stall_act) begin
                    state_d = StStall;
                end else begin
                    state_d = StRun;
                end
            end
        endcase
    end

    // FSM state and post-reset enable.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= StRun;
            live_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            live_q  <= 1'b1;
        end
    end

    // Sticky timeout: set on the edge that brings the hold timer to TIMEOUT.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            tmo_q <= 1'b0;
        end else if (hold_act && (timer >= TmrMax - 1'b1)) begin
            tmo_q <= 1'b1;
        end
    end

    sat_counter #(
        .W   (CNT_W)
    ) u_stall_cnt (
        .clk_i  (clock),
        .rst_ni (reset_n),
        .inc_i  (stall_act),
        .clr_i  (1'b0),
        .cnt_o  (stall_cnt)
    );

    sat_counter #(
        .W   (CNT_W)
    ) u_hold_cnt (
        .clk_i  (clock),
        .rst_ni (reset_n),
        .inc_i  (hold_act),
        .clr_i  (1'b0),
        .cnt_o  (hold_cnt)
    );

    // Consecutive-hold timer; any non-hold cycle restarts it.
    sat_counter #(
        .W   (TmrW),
        .MAX (TmrMax)
    ) u_hold_timer (
        .clk_i  (clock),
        .rst_ni (reset_n),
        .inc_i  (hold_act),
        .clr_i  (!hold_act),
        .cnt_o  (timer)
    );

    assign bus.stall_cycles = stall_cnt;
    assign bus.hold_cycles  = hold_cnt;
    assign bus.mem_timeout  = tmo_q;

endmodule

// File: tb/tb_load_use_stall_unit.sv
// Directed bench for load_use_stall_unit: a vector table plus multi-cycle sequences.
module tb_load_use_stall_unit;
    import mips_defs::*;

    localparam int unsigned CNT_W   = 16;
    localparam int unsigned TIMEOUT = 4;

    // Expected {pc_write, ifid_write, idex_flush, pipe_hold}.
    localparam logic [3:0] RUN_C = 4'b1100;
    localparam logic [3:0] STL_C = 4'b0010;
    localparam logic [3:0] HLD_C = 4'b0001;
    localparam logic [5:0] OP_ADDI = 6'h08;

    typedef struct {
        logic [5:0] iop;
        logic [4:0] irs;
        logic [4:0] irt;
        logic [5:0] xop;
        logic [4:0] xrt;
        logic [5:0] mop;
        logic [4:0] mrd;
        logic       rdy;
        logic [3:0] ctl;
    } vec_t;

    logic clock   = 1'b0;
    logic reset_n = 1'b0;
    int   n_cmp   = 0;
    int   n_bad   = 0;
    vec_t vecs[17];

    always #5 clock = ~clock;

    load_use_stall_unit_if #(.CNT_W(CNT_W)) bus ();

    load_use_stall_unit #(
        .CNT_W   (CNT_W),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic chk_ctl(input string name, input logic [3:0] exp);
        chk(name, {28'd0, bus.pc_write, bus.ifid_write, bus.idex_flush, bus.pipe_hold},
            {28'd0, exp});
    endtask

    task automatic drive(input logic [5:0] iop, input logic [4:0] irs, input logic [4:0] irt,
                         input logic [5:0] xop, input logic [4:0] xrt,
                         input logic [5:0] mop, input logic [4:0] mrd, input logic rdy);
        bus.ifid_op   = iop;
        bus.ifid_rs   = irs;
        bus.ifid_rt   = irt;
        bus.idex_op   = xop;
        bus.idex_rt   = xrt;
        bus.exmem_op  = mop;
        bus.exmem_rd  = mrd;
        bus.mem_ready = rdy;
    endtask

    // One pipeline cycle: change inputs just after the edge, sample on the falling edge.
    task automatic step(input logic [5:0] iop, input logic [4:0] irs, input logic [4:0] irt,
                        input logic [5:0] xop, input logic [4:0] xrt,
                        input logic [5:0] mop, input logic [4:0] mrd, input logic rdy);
        @(posedge clock);
        #1;
        drive(iop, irs, irt, xop, xrt, mop, mrd, rdy);
        @(negedge clock);
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        drive(OP_RTYPE, 5'd0, 5'd0, OP_RTYPE, 5'd0, OP_RTYPE, 5'd0, 1'b1);
        repeat (2) @(posedge clock);
        @(negedge clock);
        reset_n = 1'b1;
    endtask

    initial begin
        //           iop      irs   irt   xop      xrt   mop      mrd   rdy   ctl
        vecs[0]  = '{OP_RTYPE, 5'd0, 5'd0, OP_RTYPE, 5'd0, OP_RTYPE, 5'd0, 1'b1, RUN_C};
        vecs[1]  = '{OP_RTYPE, 5'd8, 5'd0, OP_LW,    5'd8, OP_RTYPE, 5'd0, 1'b1, STL_C};
        vecs[2]  = '{OP_SW,    5'd9, 5'd8, OP_LW,    5'd8, OP_RTYPE, 5'd0, 1'b1, RUN_C};
        vecs[3]  = '{OP_SW,    5'd8, 5'd1, OP_LW,    5'd8, OP_RTYPE, 5'd0, 1'b1, STL_C};
        vecs[4]  = '{OP_RTYPE, 5'd3, 5'd8, OP_LW,    5'd8, OP_RTYPE, 5'd0, 1'b1, STL_C};
        vecs[5]  = '{OP_ADDI,  5'd3, 5'd8, OP_LW,    5'd8, OP_RTYPE, 5'd0, 1'b1, RUN_C};
        vecs[6]  = '{OP_RTYPE, 5'd0, 5'd0, OP_LW,    5'd0, OP_RTYPE, 5'd0, 1'b1, RUN_C};
        vecs[7]  = '{OP_BEQ,   5'd5, 5'd8, OP_RTYPE, 5'd0, OP_LW,    5'd8, 1'b1, STL_C};
        vecs[8]  = '{OP_BNE,   5'd8, 5'd2, OP_RTYPE, 5'd0, OP_LW,    5'd8, 1'b1, STL_C};
        vecs[9]  = '{OP_RTYPE, 5'd8, 5'd0, OP_RTYPE, 5'd0, OP_LW,    5'd8, 1'b1, RUN_C};
        vecs[10] = '{OP_BEQ,   5'd0, 5'd0, OP_RTYPE, 5'd0, OP_LW,    5'd0, 1'b1, RUN_C};
        vecs[11] = '{OP_RTYPE, 5'd1, 5'd2, OP_RTYPE, 5'd0, OP_LW,    5'd3, 1'b0, HLD_C};
        vecs[12] = '{OP_RTYPE, 5'd8, 5'd0, OP_LW,    5'd8, OP_SW,    5'd3, 1'b0, HLD_C};
        vecs[13] = '{OP_RTYPE, 5'd1, 5'd2, OP_RTYPE, 5'd0, OP_RTYPE, 5'd3, 1'b0, RUN_C};
        vecs[14] = '{OP_BEQ,   5'd8, 5'd1, OP_RTYPE, 5'd0, OP_SW,    5'd8, 1'b1, RUN_C};
        vecs[15] = '{OP_RTYPE, 5'd8, 5'd0, OP_SW,    5'd8, OP_RTYPE, 5'd0, 1'b1, RUN_C};
        vecs[16] = '{OP_BEQ,   5'd8, 5'd9, OP_LW,    5'd8, OP_LW,    5'd9, 1'b1, STL_C};

        // Reset with a busy memory and a hazard on the inputs: RUN outputs regardless.
        drive(OP_RTYPE, 5'd8, 5'd0, OP_LW, 5'd8, OP_LW, 5'd3, 1'b0);
        #1;
        chk_ctl("reset_ctl", RUN_C);
        chk("reset_stall_cycles", 32'(bus.stall_cycles), 32'd0);
        chk("reset_hold_cycles", 32'(bus.hold_cycles), 32'd0);
        chk("reset_mem_timeout", 32'(bus.mem_timeout), 32'd0);
        repeat (2) @(posedge clock);
        @(negedge clock);
        reset_n = 1'b1;
        #1;
        chk_ctl("first_cycle_after_reset_ctl", RUN_C);
        step(OP_RTYPE, 5'd8, 5'd0, OP_LW, 5'd8, OP_LW, 5'd3, 1'b0);
        chk_ctl("after_first_edge_hold", HLD_C);
        do_reset();

        // Combinational vector table.
        for (int i = 0; i < 17; i++) begin
            step(vecs[i].iop, vecs[i].irs, vecs[i].irt, vecs[i].xop, vecs[i].xrt,
                 vecs[i].mop, vecs[i].mrd, vecs[i].rdy);
            chk_ctl($sformatf("vec%0d_ctl", i), vecs[i].ctl);
        end
        step(OP_RTYPE, 5'd0, 5'd0, OP_RTYPE, 5'd0, OP_RTYPE, 5'd0, 1'b1);
        chk("table_stall_cycles", 32'(bus.stall_cycles), 32'd6);
        chk("table_hold_cycles", 32'(bus.hold_cycles), 32'd2);
        chk("table_mem_timeout", 32'(bus.mem_timeout), 32'd0);

        // Single load-use bubble, then the load moves to MEM and ADD proceeds.
        do_reset();
        step(OP_RTYPE, 5'd8, 5'd0, OP_LW, 5'd8, OP_RTYPE, 5'd0, 1'b1);
        chk_ctl("lu_add_bubble", STL_C);
        step(OP_RTYPE, 5'd8, 5'd0, OP_RTYPE, 5'd0, OP_LW, 5'd8, 1'b1);
        chk_ctl("lu_add_release", RUN_C);
        chk("lu_add_stall_cycles", 32'(bus.stall_cycles), 32'd1);

        // Branch behind a load: lu_ex then lu_br, two bubbles.
        do_reset();
        step(OP_BEQ, 5'd8, 5'd9, OP_LW, 5'd8, OP_RTYPE, 5'd0, 1'b1);
        chk_ctl("br_bubble1", STL_C);
        step(OP_BEQ, 5'd8, 5'd9, OP_RTYPE, 5'd0, OP_LW, 5'd8, 1'b1);
        chk_ctl("br_bubble2", STL_C);
        step(OP_BEQ, 5'd8, 5'd9, OP_RTYPE, 5'd0, OP_RTYPE, 5'd0, 1'b1);
        chk_ctl("br_release", RUN_C);
        chk("br_stall_cycles", 32'(bus.stall_cycles), 32'd2);

        // Memory busy for 3 cycles over a pending load-use, then one bubble.
        do_reset();
        for (int k = 0; k < 3; k++) begin
            step(OP_RTYPE, 5'd8, 5'd0, OP_LW, 5'd8, OP_LW, 5'd5, 1'b0);
            chk_ctl($sformatf("busy_hold%0d", k), HLD_C);
        end
        step(OP_RTYPE, 5'd8, 5'd0, OP_LW, 5'd8, OP_LW, 5'd5, 1'b1);
        chk_ctl("busy_then_bubble", STL_C);
        step(OP_RTYPE, 5'd8, 5'd0, OP_RTYPE, 5'd0, OP_LW, 5'd8, 1'b1);
        chk_ctl("busy_release", RUN_C);
        chk("busy_hold_cycles", 32'(bus.hold_cycles), 32'd3);
        chk("busy_stall_cycles", 32'(bus.stall_cycles), 32'd1);

        // Timeout: set after the 4th consecutive hold cycle, sticky after release.
        do_reset();
        for (int k = 1; k <= 6; k++) begin
            step(OP_RTYPE, 5'd0, 5'd0, OP_RTYPE, 5'd0, OP_LW, 5'd4, 1'b0);
            chk($sformatf("tmo_step%0d", k), 32'(bus.mem_timeout), (k >= 5) ? 32'd1 : 32'd0);
        end
        step(OP_RTYPE, 5'd0, 5'd0, OP_RTYPE, 5'd0, OP_LW, 5'd4, 1'b1);
        chk_ctl("tmo_release_ctl", RUN_C);
        step(OP_RTYPE, 5'd0, 5'd0, OP_RTYPE, 5'd0, OP_RTYPE, 5'd0, 1'b1);
        chk("tmo_sticky", 32'(bus.mem_timeout), 32'd1);
        chk("tmo_hold_cycles", 32'(bus.hold_cycles), 32'd6);

        // Reset asserted in the middle of a hold.
        do_reset();
        for (int k = 0; k < 5; k++) begin
            step(OP_RTYPE, 5'd8, 5'd0, OP_LW, 5'd8, OP_SW, 5'd4, 1'b0);
        end
        chk("midhold_tmo_before", 32'(bus.mem_timeout), 32'd1);
        #2;
        reset_n = 1'b0;
        #1;
        chk_ctl("midhold_reset_ctl", RUN_C);
        chk("midhold_reset_stall", 32'(bus.stall_cycles), 32'd0);
        chk("midhold_reset_hold", 32'(bus.hold_cycles), 32'd0);
        chk("midhold_reset_tmo", 32'(bus.mem_timeout), 32'd0);
        do_reset();

        // Loads to $zero never stall.
        for (int k = 0; k < 3; k++) begin
            step(OP_RTYPE, 5'd0, 5'd0, OP_LW, 5'd0, OP_LW, 5'd0, 1'b1);
            chk_ctl($sformatf("zero_reg%0d", k), RUN_C);
        end
        chk("zero_reg_stall_cycles", 32'(bus.stall_cycles), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
